// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and constants for the data-memory read path
package data_mem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE_LO, ISSUE_HI, DRAIN} rd_state_t;
  localparam int ROWS_PER_TILE = 4;
  localparam int ROWS_PER_ISSUE = 2;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_MEM_DEPTH = 128;
endpackage

// File: rtl/data_rd_sched_if.sv
// data_rd_sched_if: dual-port read request bus from the scheduler to the memory wrapper
interface data_rd_sched_if import data_mem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W = 8
);
  logic [ADDR_W-1:0] addr_1_out;
  logic [ADDR_W-1:0] addr_2_out;
  logic valid_1_out;
  logic valid_2_out;
  logic phase_out;
  logic [CNT_W-1:0] tile_idx_out;
  modport master(output addr_1_out, addr_2_out, valid_1_out, valid_2_out, phase_out, tile_idx_out);
  modport slave(input addr_1_out, addr_2_out, valid_1_out, valid_2_out, phase_out, tile_idx_out);
endinterface

// File: rtl/data_rd_bounds_chk.sv
// data_rd_bounds_chk: flags a command whose last row would fall outside the SRAM
module data_rd_bounds_chk import data_mem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W = 8,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int TILE_STRIDE = 2
)(
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_tiles,
  output logic              over
);
  localparam int W = ADDR_W + CNT_W + 1;
  logic [W-1:0] last;
  assign last = W'(base_addr) + W'(num_tiles - CNT_W'(1)) * W'(TILE_STRIDE) + W'(ROWS_PER_TILE - 1);
  assign over = last >= W'(MEM_DEPTH);
endmodule

// File: rtl/data_rd_sched.sv
// data_rd_sched: issues the four rows of each overlapping Winograd tile, two per cycle
module data_rd_sched import data_mem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int TILE_STRIDE = 2,
  parameter int CNT_W = 8,
  parameter int MEM_LAT = 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_tiles,
  input  logic              hold,
  input  logic              scan_mode,
  data_rd_sched_if.master   rd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              aborted
);
  rd_state_t state;
  logic [ADDR_W-1:0] b;
  logic [ADDR_W-1:0] nb;
  logic [CNT_W-1:0] last_idx;
  logic [7:0] dcnt;
  logic over;
  assign nb = b + ADDR_W'(TILE_STRIDE);
  data_rd_bounds_chk #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .MEM_DEPTH(MEM_DEPTH), .TILE_STRIDE(TILE_STRIDE)
  ) u_chk (
    .base_addr(base_addr), .num_tiles(num_tiles), .over(over)
  );
  // outputs show the state's request; scan_mode abort beats hold and drain
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      b <= '0;
      last_idx <= '0;
      dcnt <= '0;
      rd.addr_1_out <= '0;
      rd.addr_2_out <= '0;
      rd.valid_1_out <= 1'b0;
      rd.valid_2_out <= 1'b0;
      rd.phase_out <= 1'b0;
      rd.tile_idx_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      aborted <= 1'b0;
      if (state != IDLE && scan_mode) begin
        state <= IDLE;
        rd.valid_1_out <= 1'b0;
        rd.valid_2_out <= 1'b0;
        busy <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start && !scan_mode) begin
            if (num_tiles == '0) done <= 1'b1;
            else if (over) err <= 1'b1;
            else begin
              state <= ISSUE_LO;
              busy <= 1'b1;
              b <= base_addr;
              last_idx <= num_tiles - CNT_W'(1);
              rd.tile_idx_out <= '0;
              rd.addr_1_out <= base_addr;
              rd.addr_2_out <= base_addr + ADDR_W'(1);
              rd.valid_1_out <= 1'b1;
              rd.valid_2_out <= 1'b1;
              rd.phase_out <= 1'b0;
            end
          end
          ISSUE_LO, ISSUE_HI: if (hold) begin
            rd.valid_1_out <= 1'b0;
            rd.valid_2_out <= 1'b0;
          end else if (state == ISSUE_LO) begin
            state <= ISSUE_HI;
            rd.addr_1_out <= b + ADDR_W'(ROWS_PER_ISSUE);
            rd.addr_2_out <= b + ADDR_W'(ROWS_PER_ISSUE + 1);
            rd.valid_1_out <= 1'b1;
            rd.valid_2_out <= 1'b1;
            rd.phase_out <= 1'b1;
          end else if (rd.tile_idx_out == last_idx) begin
            rd.valid_1_out <= 1'b0;
            rd.valid_2_out <= 1'b0;
            if (MEM_LAT <= 1) begin
              state <= IDLE;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              state <= DRAIN;
              dcnt <= 8'd1;
            end
          end else begin
            state <= ISSUE_LO;
            b <= nb;
            rd.tile_idx_out <= rd.tile_idx_out + CNT_W'(1);
            rd.addr_1_out <= nb;
            rd.addr_2_out <= nb + ADDR_W'(1);
            rd.valid_1_out <= 1'b1;
            rd.valid_2_out <= 1'b1;
            rd.phase_out <= 1'b0;
          end
          default: if (dcnt >= 8'(MEM_LAT - 1)) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end else dcnt <= dcnt + 8'd1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_data_rd_sched.sv
// tb_data_rd_sched: vector table plus hand sequences for hold, abort and reset corners
module tb_data_rd_sched;
  logic clk = 1'b0;
  logic reset, start, hold, scan_mode;
  logic [7:0] base_addr, num_tiles;
  logic busy, done, err, aborted;
  int total = 0;
  int bad = 0;
  data_rd_sched_if #(.ADDR_W(8), .CNT_W(8)) rd();
  data_rd_sched dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_tiles(num_tiles),
    .hold(hold), .scan_mode(scan_mode), .rd(rd.master),
    .busy(busy), .done(done), .err(err), .aborted(aborted)
  );
  always #5 clk = ~clk;
  typedef struct {
    int base;
    int n;
    int hs;
    int hl;
    bit ks;
    bit exp_err;
    int exp_done;
  } vec_t;
  vec_t vecs[15];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [30:0] outs();
    return {busy, done, err, aborted, rd.valid_1_out, rd.valid_2_out, rd.phase_out,
            rd.tile_idx_out, rd.addr_1_out, rd.addr_2_out};
  endfunction
  task automatic run_vec(input vec_t v);
    int q, kmax, done_at, tile;
    bit mst, mb, ev, ed, ee, eph;
    logic [7:0] ea1, ea2, ei;
    logic [30:0] got, exp;
    q = 0; done_at = 0; mst = 0; mb = 0; ev = 0; eph = 0;
    ea1 = '0; ea2 = '0; ei = '0;
    kmax = v.exp_done > 0 ? v.exp_done + 2 : 4;
    base_addr = 8'(v.base);
    num_tiles = 8'(v.n);
    for (int k = 0; k < kmax; k++) begin
      start = (k == 0) || (v.ks && k <= 2);
      hold = (k >= v.hs) && (k < v.hs + v.hl);
      ed = 0; ee = 0;
      if (!mst) begin
        ev = 0;
        if (start) begin
          if (v.n == 0) ed = 1;
          else if (v.exp_err) ee = 1;
          else begin mst = 1; mb = 1; q = 0; ev = 1; end
        end
      end else if (hold) ev = 0;
      else if (q == 2 * v.n - 1) begin ev = 0; ed = 1; mb = 0; mst = 0; end
      else begin q++; ev = 1; end
      if (mst && ev) begin
        tile = q / 2;
        eph = q[0];
        ea1 = 8'(v.base + 2 * tile + 2 * q[0]);
        ea2 = ea1 + 8'd1;
        ei = 8'(tile);
      end
      step();
      got = outs();
      if (done && done_at == 0) done_at = k + 1;
      exp = {mb, ed, ee, 1'b0, ev, ev, eph, ei, ea1, ea2};
      if (!mb) begin
        exp[24:0] = '0;
        got[24:0] = '0;
      end
      chk($sformatf("vec b=%0d n=%0d cyc%0d", v.base, v.n, k + 1), 64'(got), 64'(exp));
    end
    start = 0;
    hold = 0;
    chk($sformatf("done_cycle b=%0d n=%0d", v.base, v.n), 64'(done_at), 64'(v.exp_done));
    step();
  endtask
  initial begin
    bit any_done;
    vec_t v;
    vecs = '{
      '{10, 3, -1, 0, 0, 0, 7},
      '{10, 3, 4, 2, 0, 0, 9},
      '{120, 2, -1, 0, 0, 0, 5},
      '{122, 2, -1, 0, 0, 0, 5},
      '{123, 2, -1, 0, 0, 1, 0},
      '{50, 0, -1, 0, 0, 0, 1},
      '{0, 1, 1, 1, 0, 0, 4},
      '{40, 2, 0, 1, 0, 0, 5},
      '{124, 1, -1, 0, 0, 0, 3},
      '{125, 1, -1, 0, 0, 1, 0},
      '{0, 63, -1, 0, 0, 0, 127},
      '{0, 64, -1, 0, 0, 1, 0},
      '{250, 1, -1, 0, 0, 1, 0},
      '{60, 3, -1, 0, 1, 0, 7},
      '{0, 255, -1, 0, 0, 1, 0}
    };
    reset = 1; start = 0; hold = 0; scan_mode = 0; base_addr = '0; num_tiles = '0;
    step();
    step();
    chk("reset_state", 64'(outs()), 64'(0));
    reset = 0;
    step();
    foreach (vecs[i]) run_vec(vecs[i]);
    start = 1; scan_mode = 1; base_addr = 8'd10; num_tiles = 8'd2;
    step();
    start = 0; scan_mode = 0;
    chk("scan_start_ignored", 64'({busy, done, err, aborted, rd.valid_1_out}), 64'(0));
    step();
    start = 1; base_addr = 8'd20; num_tiles = 8'd4;
    step();
    start = 0;
    step();
    step();
    chk("abort_pre_lo2", 64'({rd.valid_1_out, rd.addr_1_out, rd.addr_2_out, rd.tile_idx_out, rd.phase_out}),
        64'({1'b1, 8'd22, 8'd23, 8'd1, 1'b0}));
    scan_mode = 1;
    step();
    scan_mode = 0;
    chk("abort_pulse", 64'({busy, done, aborted, rd.valid_1_out, rd.valid_2_out}), 64'(5'b00100));
    any_done = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      any_done |= done | aborted | busy;
    end
    chk("abort_quiet", 64'(any_done), 64'(0));
    v = '{20, 1, -1, 0, 0, 0, 3};
    run_vec(v);
    start = 1; base_addr = 8'd30; num_tiles = 8'd1;
    step();
    start = 0;
    step();
    chk("rst_pre_hi", 64'({rd.valid_1_out, rd.addr_1_out, rd.phase_out}), 64'({1'b1, 8'd32, 1'b1}));
    reset = 1;
    step();
    reset = 0;
    chk("rst_drain_outs", 64'(outs()), 64'(0));
    step();
    chk("rst_no_done", 64'({done, busy}), 64'(0));
    v = '{30, 2, -1, 0, 0, 0, 5};
    run_vec(v);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
